instr_fetch_unit: RTL

Instruction fetch stage for the MIPS core: holds the PC, issues word reads to the synchronous instruction memory, and presents fetched instructions with their PC to the decode stage under a valid/ready handshake. Bits [31:26] of `instr_o` drive the decoder's `instr_op_i`. Branch/jump redirects from execute flush buffered and in-flight fetches.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/fetch_skid_fifo.sv | 70 +++++++
 rtl/instr_fetch_unit.sv | 97 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared across the MIPS core.
//   INSTR_W          instruction word width
//   OPCODE_MSB/LSB   opcode field position inside an instruction word
//   RESET_PC_DEFAULT default fetch address after reset
//   OP_*             primary opcode values used by the decoder
//   fetch_entry_t    {instr, pc} pair buffered between fetch and decode
package cpu_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

  function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry buffer of fetched {instr, pc} pairs.
//   clk_i, rst_i  clock, synchronous active-high reset
//   flush_i       drop all entries (redirect); wins over push/pop
//   push_i        write push_data_i at the tail
//   pop_i         remove the head entry (ignored when empty)
//   push_data_i   entry to write
//   head_o        oldest entry, meaningful when count_o != 0
//   count_o       number of stored entries, 0..2
// Push and pop in the same cycle are legal at any fill level; at full the
// pop frees the slot the push uses.
module fetch_skid_fifo
  import cpu_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t push_data_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t entry0;  // head
  fetch_entry_t entry1;
  logic [1:0]   count;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop_i && (count != 2'd0);
  // A push into a full FIFO without a simultaneous pop is dropped here and
  // flagged by the assertion below; the issue rule upstream prevents it.
  assign do_push = push_i && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= push_data_i;
          else               entry1 <= push_data_i;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            entry0 <= push_data_i;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_o  = entry0;
  assign count_o = count;

  no_overflow: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    !(push_i && (count == 2'd2) && !pop_i));

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MIPS fetch stage. Holds the PC, issues word reads to a
// synchronous instruction memory (data one cycle after the request) and
// hands {instr, pc} to decode.
//   clk_i, rst_i          clock, synchronous active-high reset
//   imem_req_o/addr_o     read request and word-aligned byte address
//   imem_rdata_i          read data for last cycle's request
//   instr_valid_o         instr_o/pc_o/pc_plus4_o hold an instruction
//   instr_ready_i         decode accepts this cycle
//   instr_o, pc_o         head instruction and its address (0 when invalid)
//   pc_plus4_o            pc_o + 4 mod 2^32 (0 when invalid)
//   redirect_i/_pc_i      taken branch/jump from execute; flushes fetch
//
// Handshake: an instruction transfers in a cycle where instr_valid_o and
// instr_ready_i are both high. While instr_valid_o is high and ready is low,
// the presented instruction and PC stay unchanged until accepted; only a
// redirect or reset may withdraw it. instr_valid_o does not depend on
// instr_ready_i.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [31:0]        imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        pc_plus4_o,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i
);

  logic [31:0]  fetch_pc;
  logic [31:0]  inflight_pc;
  logic         inflight;
  logic [31:0]  redirect_target;
  logic         pop;
  logic         push;
  logic [1:0]   count;
  logic [1:0]   count_after_pop;
  logic [1:0]   occupancy;
  fetch_entry_t head;
  fetch_entry_t push_entry;

  assign redirect_target = redirect_pc_i & 32'hFFFF_FFFC;

  // Slots committed after this cycle: entries left once the head is popped
  // plus the response that lands at the end of this cycle. A new request is
  // only issued if its response is guaranteed a slot next cycle.
  assign count_after_pop = count - {1'b0, pop};
  assign occupancy       = count_after_pop + {1'b0, inflight};

  assign instr_valid_o = !rst_i && !redirect_i && (count != 2'd0);
  assign pop           = instr_valid_o && instr_ready_i;
  assign imem_req_o    = !rst_i && !redirect_i && (occupancy < 2'd2);
  assign imem_addr_o   = imem_req_o ? fetch_pc : 32'h0;

  // The response to a request issued before a redirect is discarded here.
  assign push       = inflight && !redirect_i;
  assign push_entry = '{instr: imem_rdata_i, pc: inflight_pc};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC & 32'hFFFF_FFFC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
    end else begin
      inflight <= imem_req_o;
      if (redirect_i) begin
        fetch_pc <= redirect_target;
      end else if (imem_req_o) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
    end
  end

  fetch_skid_fifo u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_i),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (push_entry),
    .head_o      (head),
    .count_o     (count)
  );

  assign instr_o    = instr_valid_o ? head.instr : '0;
  assign pc_o       = instr_valid_o ? head.pc : 32'h0;
  assign pc_plus4_o = instr_valid_o ? (head.pc + 32'd4) : 32'h0;

endmodule
